gather_shared_halves: RTL

- Upstream neighbour of the shared-bitvector join stage.
- Accepts masked half-width words one beat at a time: low half first, then high half. Each beat carries all shares.
- Assembles the two beats into a registered [1:0][NUM_SHARES][HALF_WIDTH] array (index 0 = low half). A downstream join concatenates this array per share.
- Shares stay in separate registers; no logic ever combines different shares.

---
 rtl/gather_shared_halves_pkg.sv | 17 +
 rtl/gather_shared_halves_shared_reg_en.sv | 26 ++
 rtl/gather_shared_halves.sv | 81 ++++++++
 3 files changed

// File: rtl/gather_shared_halves_pkg.sv
// Shared types for the masked half-word gather stage: control states and
// the share-separated half-word / split-word containers.
package gather_shared_halves_pkg;

  localparam int NUM_SHARES_P = 2;
  localparam int HALF_WIDTH_P = 15;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HAVE_LO = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  typedef logic [NUM_SHARES_P-1:0][HALF_WIDTH_P-1:0] shared_half_t;
  typedef shared_half_t [1:0]                        split_word_t;

endpackage

// File: rtl/gather_shared_halves_shared_reg_en.sv
// Enabled register with one independent flop bank per share, so no logic
// ever sees two shares of the same value together.
module shared_reg_en #(
  parameter int NUM_SHARES = 2,
  parameter int HALF_WIDTH = 15
) (
  input  logic                                  in_clock,
  input  logic                                  in_reset,
  input  logic                                  in_en,
  input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] in_d,
  output logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] out_q
);

  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0] r_q;

  for (genvar s = 0; s < NUM_SHARES; s++) begin : g_share
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
    always_ff @(posedge in_clock) begin
      if (in_reset)   r_q[s] <= '0;
      else if (in_en) r_q[s] <= in_d[s];
    end
  end

  assign out_q = r_q;

endmodule

// File: rtl/gather_shared_halves.sv
// Gathers a low then a high masked half-word beat into one registered split
// word, with valid/ready on both sides and an abort that drops the word.
module gather_shared_halves
  import gather_shared_halves_pkg::*;
#(
  parameter int NUM_SHARES = NUM_SHARES_P,
  parameter int HALF_WIDTH = HALF_WIDTH_P
) (
  input  logic                                        in_clock,
  input  logic                                        in_reset,
  input  logic                                        in_valid,
  output logic                                        out_ready,
  input  logic [NUM_SHARES-1:0][HALF_WIDTH-1:0]       in_half,
  input  logic                                        in_abort,
  output logic                                        out_valid,
  input  logic                                        in_ready,
  output logic [1:0][NUM_SHARES-1:0][HALF_WIDTH-1:0]  out_halves
);

  state_t r_state;
  state_t w_next_state;
  logic   w_accept;
  logic   w_consume;
  logic   w_en_lo;
  logic   w_en_hi;

  assign out_valid = (r_state == ST_FULL);
  assign out_ready = !in_abort && ((r_state != ST_FULL) || in_ready);
  assign w_accept  = in_valid && out_ready;
  assign w_consume = out_valid && in_ready && !in_abort;

  always_ff @(posedge in_clock) begin
    if (in_reset) r_state <= ST_EMPTY;
    else          r_state <= w_next_state;
  end

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    w_next_state = r_state;
    w_en_lo      = 1'b0;
    w_en_hi      = 1'b0;
    if (in_abort) begin
      w_next_state = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: if (w_accept) begin
          w_en_lo      = 1'b1;
          w_next_state = ST_HAVE_LO;
        end
        ST_HAVE_LO: if (w_accept) begin
          w_en_hi      = 1'b1;
          w_next_state = ST_FULL;
        end
        ST_FULL: if (w_consume) begin
          // Accept here implies consume; a new beat restarts the low half.
          w_en_lo      = w_accept;
          w_next_state = w_accept ? ST_HAVE_LO : ST_EMPTY;
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Abort deliberately leaves the data flops alone; stale shares stay masked.
  shared_reg_en #(.NUM_SHARES(NUM_SHARES), .HALF_WIDTH(HALF_WIDTH)) u_lo (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_en    (w_en_lo),
    .in_d     (in_half),
    .out_q    (out_halves[0])
  );

  shared_reg_en #(.NUM_SHARES(NUM_SHARES), .HALF_WIDTH(HALF_WIDTH)) u_hi (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_en    (w_en_hi),
    .in_d     (in_half),
    .out_q    (out_halves[1])
  );

endmodule
